// File: rtl/flp_rx.sv
// Fast-link-pulse burst receiver: decodes 17 clock / 16 data pulse bursts into a 16-bit code word.
// Define FLP_RX_MATCH_EN to enable the three-consecutive-matching-words (ability_match) detector.
module flp_rx #(
  parameter int CLK_DATA_MIN = 1110,
  parameter int CLK_DATA_MAX = 1390,
  parameter int CLK_CLK_MIN  = 2220,
  parameter int CLK_CLK_MAX  = 2780
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [15:0] code_word,
  output logic        word_valid,
  output logic        word_err,
  output logic        link_pulse,
  output logic        ability_match
);

  localparam logic [11:0] D_MIN    = 12'(CLK_DATA_MIN);
  localparam logic [11:0] D_MAX    = 12'(CLK_DATA_MAX);
  localparam logic [11:0] D_MAX_P1 = 12'(CLK_DATA_MAX + 1);
  localparam logic [11:0] C_MIN    = 12'(CLK_CLK_MIN);
  localparam logic [11:0] C_MAX    = 12'(CLK_CLK_MAX);
  localparam logic [11:0] C_MAX_P1 = 12'(CLK_CLK_MAX + 1);

  typedef enum logic [1:0] {IDLE, WAIT_DATA, WAIT_CLK, HOLDOFF} state_t;

  state_t      state_reg, state_next;
  logic        sync1_reg, sync2_reg, sync3_reg;
  logic [11:0] timer_reg;
  logic        phase_reg;
  logic [4:0]  bit_cnt_reg;
  logic [15:0] shift_reg;
  logic [15:0] code_word_reg;
  logic        word_valid_reg, word_err_reg;

  logic pulse;
  logic timer_clr, start, bit_wr, bit_val, load_word, err;

  assign pulse = sync2_reg & ~sync3_reg;

  always_comb begin
    state_next = state_reg;
    timer_clr  = 1'b0;
    start      = 1'b0;
    bit_wr     = 1'b0;
    bit_val    = 1'b0;
    load_word  = 1'b0;
    err        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pulse) begin
          start      = 1'b1;
          timer_clr  = 1'b1;
          state_next = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        // Any pulse outside the data window aborts; a pulse beats a same-cycle timeout.
        if (pulse) begin
          if (timer_reg >= D_MIN && timer_reg <= D_MAX) begin
            bit_wr     = 1'b1;
            bit_val    = 1'b1;
            state_next = WAIT_CLK;
          end else begin
            err = 1'b1;
          end
        end else if (timer_reg >= D_MAX_P1) begin
          bit_wr     = 1'b1;
          state_next = WAIT_CLK;
        end
      end
      WAIT_CLK: begin
        if (pulse) begin
          if (timer_reg >= C_MIN && timer_reg <= C_MAX) begin
            timer_clr = 1'b1;
            if (bit_cnt_reg == 5'd16) begin
              load_word  = 1'b1;
              state_next = IDLE;
            end else begin
              state_next = WAIT_DATA;
            end
          end else begin
            err = 1'b1;
          end
        end else if (timer_reg >= C_MAX_P1) begin
          err = 1'b1;
        end
      end
      HOLDOFF: begin
        if (pulse) begin
          timer_clr = 1'b1;
        end else if (timer_reg >= C_MAX_P1) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Holdoff measures quiet time from the abort itself.
    if (err) begin
      timer_clr  = 1'b1;
      state_next = HOLDOFF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      sync1_reg      <= 1'b0;
      sync2_reg      <= 1'b0;
      sync3_reg      <= 1'b0;
      timer_reg      <= 12'd0;
      phase_reg      <= 1'b0;
      bit_cnt_reg    <= 5'd0;
      shift_reg      <= 16'h0000;
      code_word_reg  <= 16'h0000;
      word_valid_reg <= 1'b0;
      word_err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      sync1_reg <= rx;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
      // Timer advances at half the clock rate and saturates.
      if (timer_clr) begin
        timer_reg <= 12'd0;
        phase_reg <= 1'b0;
      end else begin
        phase_reg <= ~phase_reg;
        if (phase_reg && timer_reg != 12'hFFF)
          timer_reg <= timer_reg + 12'd1;
      end
      if (start) begin
        bit_cnt_reg <= 5'd0;
        shift_reg   <= 16'h0000;
      end else if (bit_wr) begin
        shift_reg[bit_cnt_reg[3:0]] <= bit_val;
        bit_cnt_reg                 <= bit_cnt_reg + 5'd1;
      end
      word_valid_reg <= load_word;
      word_err_reg   <= err;
      if (load_word)
        code_word_reg <= shift_reg;
    end
  end

`ifdef FLP_RX_MATCH_EN
  logic [15:0] prev_word_reg;
  logic [1:0]  match_cnt_reg;

  // Bit 14 is the Ack bit and is allowed to differ between matching words.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_word_reg <= 16'h0000;
      match_cnt_reg <= 2'd0;
    end else if (err) begin
      match_cnt_reg <= 2'd0;
    end else if (load_word) begin
      prev_word_reg <= shift_reg;
      if (((shift_reg ^ prev_word_reg) & 16'hBFFF) == 16'h0000) begin
        if (match_cnt_reg != 2'd3)
          match_cnt_reg <= match_cnt_reg + 2'd1;
      end else begin
        match_cnt_reg <= 2'd1;
      end
    end
  end

  assign ability_match = (match_cnt_reg == 2'd3);
`else
  assign ability_match = 1'b0;
`endif

  assign code_word  = code_word_reg;
  assign word_valid = word_valid_reg;
  assign word_err   = word_err_reg;
  assign link_pulse = pulse;

endmodule

// File: tb/tb_flp_rx.sv
// Directed/randomized bench for flp_rx using scaled timing windows and a burst-level reference model.
// Expectations for ability_match follow FLP_RX_MATCH_EN.
module tb_flp_rx;

  localparam int DMIN = 40;
  localparam int DMAX = 60;
  localparam int CMIN = 90;
  localparam int CMAX = 120;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic [15:0] code_word;
  logic        word_valid, word_err, link_pulse, ability_match;

  int vectors = 0;
  int miscompares = 0;
  int n_valid = 0, n_err = 0, n_link = 0, n_both = 0;

  int dt_a[16];
  int ct_a[17];
  int omit_clk, abort_bit, pulses_sent;
  int burst_no = 0;
  logic [15:0] last_good = 16'h0000;
  logic [15:0] prev_good = 16'h0000;
  int run = 0;

  flp_rx #(
    .CLK_DATA_MIN(DMIN), .CLK_DATA_MAX(DMAX),
    .CLK_CLK_MIN(CMIN),  .CLK_CLK_MAX(CMAX)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .code_word(code_word), .word_valid(word_valid), .word_err(word_err),
    .link_pulse(link_pulse), .ability_match(ability_match)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (word_valid) n_valid++;
    if (word_err) n_err++;
    if (link_pulse) n_link++;
    if (word_valid && word_err) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse();
    rx = 1'b1;
    pulses_sent++;
    @(posedge clk);
    #1;
    rx = 1'b0;
  endtask

  task automatic set_nominal();
    for (int i = 0; i < 16; i++) dt_a[i] = (DMIN + DMAX) / 2;
    for (int i = 0; i < 17; i++) ct_a[i] = (CMIN + CMAX) / 2;
    omit_clk  = -1;
    abort_bit = -1;
  endtask

  task automatic set_random();
    set_nominal();
    for (int i = 0; i < 16; i++) dt_a[i] = int'($urandom_range(DMAX, DMIN));
    for (int i = 0; i < 17; i++) ct_a[i] = int'($urandom_range(CMAX, CMIN));
  endtask

  // A pulse detected k cycles after a clock pulse sees timer value (k-1)/2, so a
  // pulse meant to land at timer T is driven 2*T+1 cycles after the clock pulse.
  task automatic send_burst(input logic [15:0] w);
    int elapsed;
    pulses_sent = 0;
    pulse();
    for (int i = 0; i < 16; i++) begin
      if (abort_bit == i) return;
      elapsed = 1;
      if (w[i]) begin
        gap(2 * dt_a[i] + 1 - elapsed);
        pulse();
        elapsed = 2 * dt_a[i] + 2;
      end
      gap(2 * ct_a[i+1] + 1 - elapsed);
      if (omit_clk != i + 1) pulse();
      else gap(1);
    end
  endtask

  function automatic bit burst_ok(input logic [15:0] w);
    for (int i = 0; i < 16; i++) begin
      if (omit_clk == i + 1) return 1'b0;
      if (ct_a[i+1] < CMIN || ct_a[i+1] > CMAX) return 1'b0;
      if (w[i] && (dt_a[i] < DMIN || dt_a[i] > DMAX)) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic exp_ability();
`ifdef FLP_RX_MATCH_EN
    return (run >= 3);
`else
    return 1'b0;
`endif
  endfunction

  task automatic run_burst(input string tag, input logic [15:0] w);
    int v0, e0, l0;
    bit ok;
    v0 = n_valid;
    e0 = n_err;
    l0 = n_link;
    send_burst(w);
    gap(2 * CMAX + 20);
    ok = burst_ok(w);
    if (ok) begin
      if (run > 0 && ((w ^ prev_good) & 16'hBFFF) == 16'h0000)
        run = (run < 3) ? run + 1 : 3;
      else
        run = 1;
      prev_good = w;
      last_good = w;
    end else begin
      run = 0;
    end
    burst_no++;
    $display("burst %0d %s word=%04h expect_ok=%0d valid=%0d err=%0d code_word=%04h match=%0d",
             burst_no, tag, w, ok, n_valid - v0, n_err - e0, code_word, ability_match);
    check({tag, "_valid_cnt"}, 32'(n_valid - v0), ok ? 32'd1 : 32'd0);
    check({tag, "_err_cnt"},   32'(n_err - e0),   ok ? 32'd0 : 32'd1);
    check({tag, "_code_word"}, 32'(code_word),    32'(last_good));
    check({tag, "_link_cnt"},  32'(n_link - l0),  32'(pulses_sent));
    check({tag, "_ability"},   32'(ability_match), 32'(exp_ability()));
  endtask

  initial begin
    int e0, l0;
    reset = 1'b1;
    rx    = 1'b0;
    gap(3);
    check("rst_code_word", 32'(code_word), 32'h0);
    check("rst_word_valid", 32'(word_valid), 32'h0);
    check("rst_word_err", 32'(word_err), 32'h0);
    check("rst_link_pulse", 32'(link_pulse), 32'h0);
    check("rst_ability", 32'(ability_match), 32'h0);
    reset = 1'b0;
    gap(5);

    set_nominal();
    run_burst("ideal", 16'hA5C3);

    // Inclusive window edges on every data and clock pulse.
    set_nominal();
    for (int i = 0; i < 16; i++) dt_a[i] = (i % 2 == 0) ? DMIN : DMAX;
    for (int i = 0; i < 17; i++) ct_a[i] = (i % 2 == 0) ? CMIN : CMAX;
    run_burst("edges_ffff", 16'hFFFF);
    run_burst("edges_rand", 16'($urandom));

    set_nominal();
    dt_a[3] = DMIN - 1;
    run_burst("early_data", 16'hA5CB);

    set_nominal();
    ct_a[5] = CMAX + 1;
    run_burst("late_clock", 16'($urandom));

    set_nominal();
    omit_clk = 9;
    run_burst("omit_clk9", 16'h3C96);

    set_random();
    run_burst("jitter_a", 16'($urandom));
    set_random();
    run_burst("jitter_b", 16'($urandom));

    // Reset in the middle of a burst.
    set_nominal();
    abort_bit = 7;
    e0 = n_err;
    l0 = n_link;
    send_burst(16'h5A5A);
    gap(5);
    check("abort_link_cnt", 32'(n_link - l0), 32'(pulses_sent));
    reset = 1'b1;
    gap(1);
    check("midrst_code_word", 32'(code_word), 32'h0);
    check("midrst_word_valid", 32'(word_valid), 32'h0);
    check("midrst_word_err", 32'(word_err), 32'h0);
    check("midrst_link_pulse", 32'(link_pulse), 32'h0);
    check("midrst_ability", 32'(ability_match), 32'h0);
    reset = 1'b0;
    gap(5);
    check("midrst_no_err", 32'(n_err - e0), 32'h0);
    last_good = 16'h0000;
    run = 0;
    $display("burst reset_at_bit7 word=5a5a discarded");

    set_nominal();
    run_burst("after_rst", 16'h1234);
    run_burst("match_1", 16'h41E1);
    run_burst("match_2", 16'h41E1);
    run_burst("match_3", 16'h01E1);
    run_burst("match_break", 16'h41E2);

    check("valid_err_overlap", 32'(n_both), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
